frac_mult_arbiter: RTL
======================

Name: frac_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fraction_multiplier4 instance between NREQ requesters.
- Accepts one 4-bit operand pair per requester through a valid/ready handshake.
- Pulses the multiplier start input, waits for Done, captures the 7-bit product.
- Returns the product tagged with the requester index.
- Sits between the client blocks and the shared multiplier, and is the only driver of the multiplier's St/Mplier/Mcand.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester index; must equal ceil(log2(NREQ))
TIMEOUT, 31, maximum cycles in BUSY before abort (used only with the watchdog macro)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  one-hot acceptance pulse
req_mplier  in  4*NREQ  flattened multiplier operands, requester i at [4i+3:4i]
req_mcand  in  4*NREQ  flattened multiplicand operands
rsp_valid  out  1  response held valid
rsp_ready  in  1  response consumer accept
rsp_id  out  IDW  requester index of the response
rsp_product  out  7  product from the multiplier
rsp_err  out  1  response is a timeout abort (always 0 without the macro)
mul_st  out  1  to multiplier St
mul_mplier  out  4  to multiplier Mplier
mul_mcand  out  4  to multiplier Mcand
mul_product  in  7  from multiplier Product
mul_done  in  1  from multiplier Done

Behaviour:
- One clock, CLK. Reset RST_N is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, rsp_err=0.
  - mul_st=0, mul_mplier=0, mul_mcand=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- State IDLE:
  - If any req_valid is set, grant the first set bit searching from last+1 upward with wrap-around.
  - In the same cycle, assert req_ready[g]=1 for one cycle only.
  - Register the granted operands into mul_mplier/mul_mcand, store g in an id register, set last=g, go to ISSUE.
  - With no request, stay in IDLE.
- State ISSUE: mul_st=1 for exactly one cycle, operands stable, then go to BUSY.
- State BUSY:
  - Operands stay stable and mul_st=0.
  - mul_done is ignored during the first BUSY cycle, because the multiplier state has not advanced yet.
  - From the second BUSY cycle on, mul_done=1 captures mul_product into rsp_product and the id register into rsp_id, sets rsp_err=0, and goes to RESP.
- State RESP:
  - rsp_valid=1, held until rsp_valid&&rsp_ready.
  - On that handshake, clear rsp_valid and go to IDLE.
  - No new grant is issued in that same cycle, so the minimum gap between grants is one IDLE cycle.
- Handshake rules:
  - req_ready never asserts outside IDLE.
  - A requester may drop req_valid at any time before it is granted.
  - The operands sampled are those present in the grant cycle.
- Simultaneous requests: exactly one grant per cycle; strict round-robin gives every requester a bound of NREQ transactions.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - Any transaction in flight is lost with no response.
  - mul_st=0 guarantees no restart. The multiplier itself has no reset; after reset the arbiter ignores mul_done until its first ISSUE.
- Widths: product passes through unmodified, 7 bits. No arithmetic is done in this block.

Optional Feature:
Macro: FRAC_ARB_TIMEOUT_EN
- With the macro:
  - A 5-bit-or-wider cycle counter clears on entry to BUSY and counts BUSY cycles.
  - When it reaches TIMEOUT without mul_done, go to RESP with rsp_err=1 and rsp_product=0.
  - A later stray mul_done outside BUSY is ignored.
- Without the macro: no counter is built, BUSY waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Shared package frac_arb_pkg holds:
  - The state enum IDLE/ISSUE/BUSY/RESP.
  - Constants MUL_W=4 and PROD_W=7.
  - Default TIMEOUT.
- One sub-module, frac_rr_pick: combinational round-robin picker taking the request vector and last, and returning the grant index and any_valid. It is reused by other arbiters in the design.

Test Plan:
- Single request: req_valid=4'b0001, mplier=4'b0100, mcand=4'b0100 -> req_ready[0] pulse, one mul_st pulse, then rsp_valid with rsp_id=0 and rsp_product equal to the multiplier model (0.25 = 7'b0010000), rsp_err=0.
- All four requesters valid continuously -> grant order 0,1,2,3,0; exactly one req_ready bit per grant; no mul_st while BUSY or RESP.
- Back-pressure: rsp_ready=0 for 20 cycles after the response -> rsp_valid, rsp_id and rsp_product stay stable; no new grant until rsp_ready=1.
- Early Done: drive mul_done=1 in the first BUSY cycle from a stub multiplier -> ignored; completion occurs on the next Done.
- Reset in BUSY: RST_N low for 1 cycle -> all outputs zero asynchronously, state IDLE; the next request is granted to requester 0.
- With FRAC_ARB_TIMEOUT_EN and a stub that never asserts Done -> response after TIMEOUT=31 BUSY cycles with rsp_err=1 and rsp_product=0.

Source files
------------

// File: rtl/frac_arb_pkg.sv
// Shared types and constants for the fraction-multiplier arbiter and its picker.
package frac_arb_pkg;

    localparam int unsigned MUL_W           = 4;
    localparam int unsigned PROD_W          = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic [MUL_W-1:0] mplier;
        logic [MUL_W-1:0] mcand;
    } mul_ops_t;

endpackage

// File: rtl/frac_rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last', with wrap-around.
module frac_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last) + k) % N);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

endmodule

// File: rtl/frac_mult_arbiter.sv
// Round-robin sequencer sharing one fraction_multiplier4 between NREQ requesters.
// Optional BUSY watchdog enabled by defining FRAC_ARB_TIMEOUT_EN.
module frac_mult_arbiter
    import frac_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [MUL_W*NREQ-1:0]   req_mplier,
    input  logic [MUL_W*NREQ-1:0]   req_mcand,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [PROD_W-1:0]       rsp_product,
    output logic                    rsp_err,
    output logic                    mul_st,
    output logic [MUL_W-1:0]        mul_mplier,
    output logic [MUL_W-1:0]        mul_mcand,
    input  logic [PROD_W-1:0]       mul_product,
    input  logic                    mul_done
);

    if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT < 2) begin : g_bad_cfg
        $error("frac_mult_arbiter: unsupported NREQ/IDW/TIMEOUT combination");
    end

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [IDW-1:0]     id_q, id_d;
    mul_ops_t           ops_q, ops_d;
    logic               mul_st_q, mul_st_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [PROD_W-1:0]  rsp_product_q, rsp_product_d;
    logic               busy_first_q, busy_first_d;
    logic               rsp_err_d;
    logic [NREQ-1:0]    req_ready_c;
    logic [IDW-1:0]     pick_id;
    logic               pick_any;

    frac_rr_pick #(
        .N  (NREQ),
        .IW (IDW)
    ) u_pick (
        .req       (req_valid),
        .last      (last_q),
        .grant     (pick_id),
        .any_valid (pick_any)
    );

`ifdef FRAC_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 5) ? 5 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q;
`endif

    // Next-state and next-output logic; acceptance pulse is combinational in the grant cycle.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        ops_d         = ops_q;
        mul_st_d      = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        busy_first_d  = 1'b0;
        rsp_err_d     = 1'b0;
        req_ready_c   = '0;
`ifdef FRAC_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_err_d     = rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    req_ready_c[pick_id] = 1'b1;
                    ops_d.mplier = req_mplier[pick_id*MUL_W +: MUL_W];
                    ops_d.mcand  = req_mcand[pick_id*MUL_W +: MUL_W];
                    id_d         = pick_id;
                    last_d       = pick_id;
                    mul_st_d     = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                busy_first_d = 1'b1;
                state_d      = BUSY;
`ifdef FRAC_ARB_TIMEOUT_EN
                cnt_d        = '0;
`endif
            end
            BUSY: begin
                // Done in the first BUSY cycle may be stale from the previous operation.
                if (mul_done && !busy_first_q) begin
                    rsp_product_d = mul_product;
                    rsp_id_d      = id_q;
                    rsp_err_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end
`ifdef FRAC_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_product_d = '0;
                    rsp_id_d      = id_q;
                    rsp_err_d     = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            last_q        <= IDW'(NREQ - 1);
            id_q          <= '0;
            ops_q         <= '0;
            mul_st_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            busy_first_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            id_q          <= id_d;
            ops_q         <= ops_d;
            mul_st_q      <= mul_st_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            busy_first_q  <= busy_first_d;
        end
    end

`ifdef FRAC_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = rsp_err_d & 1'b0;
`endif

    assign req_ready   = req_ready_c;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign mul_st      = mul_st_q;
    assign mul_mplier  = ops_q.mplier;
    assign mul_mcand   = ops_q.mcand;

endmodule
